// File: rtl/psram_qspi_ctrl.sv
// psram_qspi_ctrl: QSPI PSRAM master. Single-beat 32-bit read (EBh) / write (38h).
// Optional macro PSRAM_CTRL_ERR_EN: flags non-contiguous wstrb and top-of-memory
// addresses as errors (no bus activity); otherwise resp_err is 0 and
// non-contiguous masks write the full word.
module psram_qspi_ctrl #(
  parameter int SCK_DIV = 1,
  parameter int CE_GAP  = 2,
  parameter int ADDR_W  = 24
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              sck,
  output logic              ce_n,
  output logic [3:0]        dio_o,
  output logic [3:0]        dio_oe,
  input  logic [3:0]        dio_i
);
  // Outgoing nibble stream: 8 cmd bits (one per nibble, on dio[0]), address, data.
  localparam int SW = 32 + ADDR_W + 32;
  localparam int CW = $clog2(CE_GAP + 8) + 1;
  localparam int DW = $clog2(SCK_DIV) + 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WAIT, RDATA, GAP, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;   // sck cycles left in state minus 1, or gap clocks left
  logic [DW-1:0] div_q;   // clocks elapsed in current sck half
  logic          hi_q;    // currently in the high half of sck
  logic          wr_q;
  logic [2:0]    nb_q;    // enabled byte count for writes
  logic [SW-1:0] sr_q;    // remaining nibbles to launch

  logic          contig, bad, nobus;
  logic [3:0]    strb;
  logic [1:0]    b0;
  logic [2:0]    nb;
  logic [7:0]    cmd;
  logic [31:0]   cmd_nib, wsh, dstr;
  logic [SW-1:0] stream;
  logic [2:0]    k;
  logic [4:0]    rd_idx;
  logic          unused_ok;

  assign unused_ok = ^req_addr[1:0];

  // Decode the incoming request into byte range, error status and bus stream.
  always_comb begin
    case (req_wstrb)
      4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0010,
      4'b0110, 4'b1110, 4'b0100, 4'b1100, 4'b1000: contig = 1'b1;
      default:                                     contig = 1'b0;
    endcase
    strb  = (contig || req_wstrb == 4'b0000) ? req_wstrb : 4'b1111;
    nobus = req_write && (req_wstrb == 4'b0000);
`ifdef PSRAM_CTRL_ERR_EN
    bad   = (req_write && !contig && req_wstrb != 4'b0000) || (&req_addr[ADDR_W-1:2]);
`else
    bad   = 1'b0;
`endif
    b0 = 2'd0;
    if (req_write) begin
      if      (strb[0]) b0 = 2'd0;
      else if (strb[1]) b0 = 2'd1;
      else if (strb[2]) b0 = 2'd2;
      else              b0 = 2'd3;
    end
    nb  = {2'b0, strb[0]} + {2'b0, strb[1]} + {2'b0, strb[2]} + {2'b0, strb[3]};
    cmd = req_write ? 8'h38 : 8'hEB;
    cmd_nib = '0;
    for (int i = 0; i < 8; i++) cmd_nib[4*i] = cmd[i];
    // Enabled bytes go out in ascending order, each high nibble first.
    wsh  = req_wdata >> {b0, 3'b000};
    dstr = req_write ? {wsh[7:0], wsh[15:8], wsh[23:16], wsh[31:24]} : 32'h0;
    stream = {cmd_nib, req_addr[ADDR_W-1:2], b0, dstr};
    // Read nibble k lands in byte k/2, even nibbles in the upper half.
    k      = 3'd7 - cnt_q[2:0];
    rd_idx = {k[2:1], ~k[0], 2'b00};
  end

  // Transaction FSM; all pin and handshake outputs are registered here.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      hi_q       <= 1'b0;
      wr_q       <= 1'b0;
      nb_q       <= '0;
      sr_q       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      sck        <= 1'b0;
      ce_n       <= 1'b1;
      dio_o      <= '0;
      dio_oe     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            wr_q       <= req_write;
            nb_q       <= nb;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            div_q      <= '0;
            hi_q       <= 1'b0;
            if (bad || nobus) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= bad;
            end else begin
              state_q <= CMD;
              cnt_q   <= CW'(7);
              ce_n    <= 1'b0;
              sr_q    <= stream << 4;
              dio_o   <= stream[SW-1 -: 4];
              dio_oe  <= 4'b0001;
            end
          end
        end
        CMD, ADDR, WDATA, WAIT, RDATA: begin
          if (div_q != DW'(SCK_DIV - 1)) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!hi_q) begin
              // End of low half: rise sck, capture read nibble.
              hi_q <= 1'b1;
              sck  <= 1'b1;
              if (state_q == RDATA) resp_rdata[rd_idx +: 4] <= dio_i;
            end else begin
              // End of high half: fall sck and launch the next nibble.
              hi_q  <= 1'b0;
              sck   <= 1'b0;
              sr_q  <= sr_q << 4;
              dio_o <= sr_q[SW-1 -: 4];
              if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
              end else begin
                case (state_q)
                  CMD: begin
                    state_q <= ADDR;
                    cnt_q   <= CW'(ADDR_W/4 - 1);
                    dio_oe  <= 4'b1111;
                  end
                  ADDR: begin
                    if (wr_q) begin
                      state_q <= WDATA;
                      cnt_q   <= CW'({nb_q, 1'b0} - 4'd1);
                    end else begin
                      state_q <= WAIT;
                      cnt_q   <= CW'(6);
                      dio_oe  <= 4'b0000;
                      dio_o   <= 4'b0000;
                    end
                  end
                  WAIT: begin
                    state_q <= RDATA;
                    cnt_q   <= CW'(7);
                  end
                  default: begin
                    state_q <= GAP;
                    cnt_q   <= CW'(CE_GAP - 1);
                    ce_n    <= 1'b1;
                    dio_oe  <= 4'b0000;
                    dio_o   <= 4'b0000;
                  end
                endcase
              end
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= IDLE;
            req_ready  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Directed bench for psram_qspi_ctrl with a behavioural QSPI PSRAM model.
module tb_psram_qspi_ctrl;
  logic        clock = 1'b0, resetn = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0, dio_i = '0;
  logic        req_ready, resp_valid, resp_err, sck, ce_n;
  logic [31:0] resp_rdata;
  logic [3:0]  dio_o, dio_oe;
  int          checks = 0, failures = 0;

  always #5 clock = ~clock;

  psram_qspi_ctrl #(.SCK_DIV(1), .CE_GAP(2), .ADDR_W(24)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .sck(sck), .ce_n(ce_n),
    .dio_o(dio_o), .dio_oe(dio_oe), .dio_i(dio_i)
  );

  // PSRAM device model
  logic [7:0]  mem [0:1023];
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_wnib = '0;
  logic [3:0]  m_prev = '0;
  int m_rises = 0, ce_falls = 0, oe_errs = 0, sck_viol = 0;
  int cyc = 0, rise_cyc = 0, min_gap = 1000;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (ce_n && sck) sck_viol++;
  always @(posedge ce_n) rise_cyc = cyc;
  always @(negedge ce_n) begin
    m_rises = 0; m_wnib = '0; ce_falls++;
    if (cyc - rise_cyc < min_gap) min_gap = cyc - rise_cyc;
  end

  always @(posedge sck) begin
    logic [3:0] eoe;
    int idx;
    if (m_rises < 8) begin
      eoe = 4'b0001; m_cmd = {m_cmd[6:0], dio_o[0]};
    end else if (m_rises < 14) begin
      eoe = 4'b1111; m_addr = {m_addr[19:0], dio_o};
    end else if (m_cmd == 8'h38) begin
      eoe = 4'b1111; idx = m_rises - 14; m_wnib = {m_wnib[27:0], dio_o};
      if (idx % 2 == 0) m_prev = dio_o;
      else mem[10'(m_addr + 24'(idx / 2))] = {m_prev, dio_o};
    end else begin
      eoe = 4'b0000;
    end
    if (dio_oe !== eoe) oe_errs++;
    m_rises++;
  end

  always @(negedge sck) begin
    int kk;
    logic [7:0] b;
    if (!ce_n && m_cmd == 8'hEB && m_rises >= 21 && m_rises < 29) begin
      kk = m_rises - 21;
      b = mem[10'(m_addr + 24'(kk / 2))];
      dio_i = (kk % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [23:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output logic er,
                     output int lat);
    int t;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clock); t++; end
    @(posedge clock); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 500) begin @(negedge clock); lat++; end
    rd = resp_rdata; er = resp_err; resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        bus;
    logic [7:0]  cmd;
    logic [23:0] baddr;
    int          rises;
    logic [31:0] wnib;
  } vec_t;

  localparam int NV = 11;
  vec_t v [NV];

  initial begin
    logic [31:0] rd;
    logic        er, ok;
    int          lat, f0, t;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[256] = 8'hEF; mem[257] = 8'hBE; mem[258] = 8'hAD; mem[259] = 8'hDE;

    //        wr    addr        wdata         strb     rdata         err  lat bus  cmd    baddr       rises wnib
    v[0]  = '{1'b0, 24'h000100, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 61, 1'b1, 8'hEB, 24'h000100, 29, 32'h0};
    v[1]  = '{1'b1, 24'h000040, 32'h11223344, 4'hF,    32'h0,        1'b0, 47, 1'b1, 8'h38, 24'h000040, 22, 32'h44332211};
    v[2]  = '{1'b0, 24'h000040, 32'h0,        4'h0,    32'h11223344, 1'b0, 61, 1'b1, 8'hEB, 24'h000040, 29, 32'h0};
    v[3]  = '{1'b1, 24'h000010, 32'hAABBCCDD, 4'b1100, 32'h0,        1'b0, 39, 1'b1, 8'h38, 24'h000012, 18, 32'h0000BBAA};
    v[4]  = '{1'b0, 24'h000010, 32'h0,        4'h0,    32'hAABB0000, 1'b0, 61, 1'b1, 8'hEB, 24'h000010, 29, 32'h0};
    v[5]  = '{1'b1, 24'h000020, 32'h55667788, 4'b0010, 32'h0,        1'b0, 35, 1'b1, 8'h38, 24'h000021, 16, 32'h00000077};
    v[6]  = '{1'b0, 24'h000020, 32'h0,        4'h0,    32'h00007700, 1'b0, 61, 1'b1, 8'hEB, 24'h000020, 29, 32'h0};
    v[7]  = '{1'b1, 24'h000050, 32'hCAFEF00D, 4'b0111, 32'h0,        1'b0, 43, 1'b1, 8'h38, 24'h000050, 20, 32'h000DF0FE};
    v[8]  = '{1'b0, 24'h000050, 32'h0,        4'h0,    32'h00FEF00D, 1'b0, 61, 1'b1, 8'hEB, 24'h000050, 29, 32'h0};
    v[9]  = '{1'b1, 24'h000060, 32'h12345678, 4'h0,    32'h0,        1'b0,  1, 1'b0, 8'h00, 24'h0,      0,  32'h0};
    v[10] = '{1'b0, 24'h000042, 32'h0,        4'h0,    32'h11223344, 1'b0, 61, 1'b1, 8'hEB, 24'h000040, 29, 32'h0};

    // Reset state
    #12;
    chk("reset outputs", 32'({ce_n, sck, dio_oe, dio_o, req_ready, resp_valid, resp_err}),
        32'({1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    chk("reset rdata", resp_rdata, 32'h0);
    @(negedge clock) resetn = 1'b1;
    @(negedge clock);
    chk("req_ready after reset", 32'(req_ready), 32'd1);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      f0 = ce_falls;
      txn(v[i].wr, v[i].addr, v[i].wdata, v[i].wstrb, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d err", i), 32'(er), 32'(v[i].err));
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      if (v[i].bus) begin
        chk($sformatf("v%0d cmd", i), 32'(m_cmd), 32'(v[i].cmd));
        chk($sformatf("v%0d bus addr", i), 32'(m_addr), 32'(v[i].baddr));
        chk($sformatf("v%0d sck cycles", i), m_rises, v[i].rises);
        chk($sformatf("v%0d oe errors", i), oe_errs, 0);
        if (v[i].wr) chk($sformatf("v%0d write nibbles", i), m_wnib, v[i].wnib);
      end else begin
        chk($sformatf("v%0d no ce pulse", i), ce_falls - f0, 0);
      end
    end

    // Back-to-back reads with response held off for 5 clocks
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000100;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clock); t++; end
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 500) begin @(negedge clock); lat++; end
    chk("b2b first latency", lat, 61);
    ok = 1'b1;
    repeat (5) begin
      if (req_ready || !resp_valid) ok = 1'b0;
      @(negedge clock);
    end
    if (req_ready || !resp_valid) ok = 1'b0;
    chk("b2b held response blocks req", 32'(ok), 32'd1);
    chk("b2b first rdata", resp_rdata, 32'hDEADBEEF);
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    chk("b2b ready after retire", 32'({req_ready, resp_valid}), 32'b10);
    @(posedge clock); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 500) begin @(negedge clock); lat++; end
    chk("b2b second rdata", resp_rdata, 32'hDEADBEEF);
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;

    // Non-contiguous byte mask
    f0 = ce_falls;
    txn(1'b1, 24'h000070, 32'h01020304, 4'b0101, rd, er, lat);
`ifdef PSRAM_CTRL_ERR_EN
    chk("noncontig err", 32'(er), 32'd1);
    chk("noncontig latency", lat, 1);
    chk("noncontig no ce pulse", ce_falls - f0, 0);
    f0 = ce_falls;
    txn(1'b0, 24'hFFFFFC, 32'h0, 4'h0, rd, er, lat);
    chk("top addr err", 32'(er), 32'd1);
    chk("top addr no ce pulse", ce_falls - f0, 0);
`else
    chk("noncontig err", 32'(er), 32'd0);
    chk("noncontig latency", lat, 47);
    chk("noncontig nibbles", m_wnib, 32'h04030201);
    txn(1'b0, 24'h000070, 32'h0, 4'h0, rd, er, lat);
    chk("noncontig readback", rd, 32'h01020304);
`endif

    // Reset in the middle of RDATA
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000100;
    t = 0;
    while (!req_ready && t < 100) begin @(negedge clock); t++; end
    @(posedge clock); #1 req_valid = 1'b0;
    t = 0;
    while (m_rises < 24 && t < 200) begin @(negedge clock); t++; end
    chk("reached RDATA", 32'(m_rises >= 24), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid-read reset pins", 32'({ce_n, sck, dio_oe, req_ready, resp_valid}),
        32'({1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
    @(negedge clock) resetn = 1'b1;
    ok = 1'b0;
    repeat (100) begin @(negedge clock); if (resp_valid) ok = 1'b1; end
    chk("no resp after reset", 32'(ok), 32'd0);
    txn(1'b0, 24'h000040, 32'h0, 4'h0, rd, er, lat);
    chk("read after reset", rd, 32'h11223344);

    chk("sck low while ce_n high", sck_viol, 0);
    chk("ce_n gap >= CE_GAP", 32'(min_gap >= 2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
